uart_tx_buf: RTL and testbench
==============================

UART_TX_BUF -- requirements
Module: uart_tx_buf

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, holding-FIFO depth in bytes (power of two, >= 2).
REQ-002 The block SHALL have parameter PARITY_EN, default 0; 1 inserts an even-parity bit after the data bits.
REQ-003 clk  input  1  single system clock; all state is updated on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 baud_tick  input  1  one-clk-wide bit-rate strobe from the baud generator; each serial bit lasts one tick interval.
REQ-006 tx_wr  input  1  write strobe; pushes tx_wdata into the FIFO.
REQ-007 tx_wdata  input  8  byte to transmit.
REQ-008 tx_full  output  1  FIFO holds DEPTH entries.
REQ-009 tx_empty  output  1  FIFO holds 0 entries.
REQ-010 tx_count  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-011 tx_ovf  output  1  sticky flag; a write was attempted while the FIFO was full.
REQ-012 tx  output  1  registered serial line; idle high; LSB first.
REQ-013 tx_busy  output  1  high from the first clk of the start bit through the last clk of the stop bit.
REQ-014 tx_done  output  1  one-clk pulse at the end of each frame's stop bit.

Function
REQ-015 FIFO write: on a clk edge with tx_wr=1 and tx_full=0, the block SHALL store tx_wdata at the tail and increment tx_count.
REQ-016 A write while tx_full=1 SHALL be discarded and SHALL set tx_ovf, even if a pop occurs on the same edge.
REQ-017 Simultaneous push and pop with the FIFO neither empty nor full SHALL leave tx_count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-018 tx_full, tx_empty and tx_count SHALL be registered and consistent on every cycle.
REQ-019 FSM states: IDLE, START, DATA, PARITY, STOP; all transitions SHALL occur only on clk edges where baud_tick=1.
REQ-020 IDLE: on baud_tick with the FIFO non-empty, pop the head into the shift register, set tx=0 and tx_busy=1, and go to START. With the FIFO empty, hold tx=1 and tx_busy=0.
REQ-021 A byte written in the same cycle as a baud_tick in IDLE with an empty FIFO SHALL NOT start a frame until the next tick.
REQ-022 START: on baud_tick, drive data bit 0, clear the 3-bit bit counter, and go to DATA.
REQ-023 DATA: on baud_tick with bit counter < 7, drive the next bit and increment the counter.
REQ-024 DATA with bit counter = 7: on baud_tick, go to PARITY and drive the XOR of the 8 data bits if PARITY_EN=1; otherwise go to STOP and drive tx=1.
REQ-025 PARITY: on baud_tick, drive tx=1 and go to STOP.
REQ-026 STOP: on baud_tick, pulse tx_done for exactly one clk. If the FIFO is non-empty, pop, drive tx=0 and go to START with tx_busy held high (back-to-back frames, no idle gap). Otherwise go to IDLE with tx=1 and tx_busy=0.
REQ-027 Frame length SHALL be 10 tick intervals (11 with PARITY_EN=1).
REQ-028 The start bit SHALL be the first bit of the frame during which tx_busy=1 and tx=0, so that the downstream receiver qualifies the start on that combination.
REQ-029 The shift register SHALL be loaded only on pop; FIFO writes during a frame SHALL NOT alter the byte in flight.
REQ-030 baud_tick held high for multiple clks SHALL advance one bit per clk (no internal edge detection).

Reset
REQ-031 On reset assertion, the block SHALL immediately set tx=1, tx_busy=0, tx_done=0, tx_ovf=0, tx_count=0, tx_empty=1 and tx_full=0, clear the pointers, and enter IDLE.
REQ-032 Reset mid-frame SHALL abort the frame and discard all FIFO contents; after release, the first frame SHALL begin no earlier than the next baud_tick following a new write.

Verification
REQ-033 Single byte: write 0xA5 in IDLE, PARITY_EN=0 -> tx sequence at successive ticks 0,1,0,1,0,0,1,0,1,1; tx_busy high for 10 intervals; one tx_done pulse; tx_empty=1 afterwards.
REQ-034 Back-to-back: write 0x00 then 0xFF -> second start bit immediately follows the first stop bit; tx_busy never drops between frames; exactly two tx_done pulses.
REQ-035 Overflow: with DEPTH=4 and no ticks, write 5 bytes 0x01..0x05 -> tx_count=4, tx_full=1, tx_ovf=1; frames then transmit 0x01..0x04 only.
REQ-036 Parity: PARITY_EN=1, byte 0x07 -> parity bit 1; byte 0x03 -> parity bit 0; frame = 11 intervals.
REQ-037 Reset mid-frame: assert reset during DATA bit 3 -> tx=1, tx_busy=0 and tx_count=0 before the next clk edge; no tx_done pulse.
REQ-038 Wrap and simultaneous events: 10 writes interleaved with pops, including a push+pop on the same edge at count=2 -> count stays 2; output byte order equals write order.

Source files
------------

// File: rtl/uart_tx_buf_if.sv
// Byte-write side of the buffered UART transmitter: write strobe/data in, FIFO status out.
interface uart_tx_buf_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          tx_wr;
  logic [7:0]    tx_wdata;
  logic          tx_full;
  logic          tx_empty;
  logic [CW-1:0] tx_count;
  logic          tx_ovf;

  modport master (
    output tx_wr, tx_wdata,
    input  tx_full, tx_empty, tx_count, tx_ovf
  );

  modport slave (
    input  tx_wr, tx_wdata,
    output tx_full, tx_empty, tx_count, tx_ovf
  );
endinterface

// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter: holding FIFO feeding an 8N1 (optionally 8E1) serializer
// paced by an external baud_tick strobe. Frames run back to back while the FIFO has data.
module uart_tx_buf #(
  parameter int DEPTH     = 4,
  parameter int PARITY_EN = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         baud_tick,
  uart_tx_buf_if.slave bus,
  output logic         tx,
  output logic         tx_busy,
  output logic         tx_done
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q, count_next;
  logic          full_q, empty_q, ovf_q;
  logic          push, pop;

  state_t        state_q, state_next;
  logic          tx_q, tx_next;
  logic          busy_q, busy_next;
  logic          done_q, done_next;
  logic [7:0]    data_q, data_next;
  logic [2:0]    cnt_q, cnt_next;

  // A write into a full FIFO is dropped even if a pop happens on the same edge.
  assign push = bus.tx_wr && !full_q;

  assign bus.tx_full  = full_q;
  assign bus.tx_empty = empty_q;
  assign bus.tx_count = count_q;
  assign bus.tx_ovf   = ovf_q;
  assign tx           = tx_q;
  assign tx_busy      = busy_q;
  assign tx_done      = done_q;

  // Next occupancy from the push/pop pair; a simultaneous push and pop cancel out.
  always_comb begin
    count_next = count_q;
    case ({push, pop})
      2'b10:   count_next = count_q + CNT_ONE;
      2'b01:   count_next = count_q - CNT_ONE;
      default: count_next = count_q;
    endcase
  end

  // FIFO pointers, registered occupancy/status flags and the sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count_q <= count_next;
      full_q  <= (count_next == FULL_CNT);
      empty_q <= (count_next == '0);
      if (bus.tx_wr && full_q) ovf_q <= 1'b1;
    end
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.tx_wdata;
  end

  // Serializer state and registered line outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_next;
      tx_q    <= tx_next;
      busy_q  <= busy_next;
      done_q  <= done_next;
      data_q  <= data_next;
      cnt_q   <= cnt_next;
    end
  end

  // Next-state/output logic; everything advances only on baud_tick, and the byte is
  // latched into data_q solely when it is popped so later writes never disturb it.
  always_comb begin
    state_next = state_q;
    tx_next    = tx_q;
    busy_next  = busy_q;
    done_next  = 1'b0;
    data_next  = data_q;
    cnt_next   = cnt_q;
    pop        = 1'b0;
    if (baud_tick) begin
      case (state_q)
        IDLE: begin
          if (!empty_q) begin
            pop        = 1'b1;
            data_next  = mem[rd_ptr];
            tx_next    = 1'b0;
            busy_next  = 1'b1;
            state_next = START;
          end else begin
            tx_next   = 1'b1;
            busy_next = 1'b0;
          end
        end
        START: begin
          tx_next    = data_q[0];
          cnt_next   = 3'd0;
          state_next = DATA;
        end
        DATA: begin
          if (cnt_q != 3'd7) begin
            tx_next  = data_q[cnt_q + 3'd1];
            cnt_next = cnt_q + 3'd1;
          end else if (PARITY_EN != 0) begin
            tx_next    = ^data_q;
            state_next = PARITY;
          end else begin
            tx_next    = 1'b1;
            state_next = STOP;
          end
        end
        PARITY: begin
          tx_next    = 1'b1;
          state_next = STOP;
        end
        STOP: begin
          done_next = 1'b1;
          if (!empty_q) begin
            pop        = 1'b1;
            data_next  = mem[rd_ptr];
            tx_next    = 1'b0;
            state_next = START;
          end else begin
            tx_next    = 1'b1;
            busy_next  = 1'b0;
            state_next = IDLE;
          end
        end
        default: begin
          tx_next    = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Directed self-checking bench for uart_tx_buf: one instance without parity (A) and
// one with even parity (B), driven by hand-placed baud ticks every 4 clocks.
module tb_uart_tx_buf;

  logic clk = 1'b0;
  logic reset;
  logic baud_tick;
  logic tx_a, tx_busy_a, tx_done_a;
  logic tx_b, tx_busy_b, tx_done_b;

  int errors = 0;
  int checks = 0;
  int busy_clks_a = 0, done_cnt_a = 0;
  int busy_clks_b = 0, done_cnt_b = 0;
  int tick_idx;
  logic rec_a [0:127];
  logic rec_b [0:127];
  logic busy_all;
  logic [7:0] wbytes [0:9];

  uart_tx_buf_if #(.DEPTH(4)) bus_a ();
  uart_tx_buf_if #(.DEPTH(4)) bus_b ();

  uart_tx_buf #(.DEPTH(4), .PARITY_EN(0)) dut_a (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .bus(bus_a.slave),
    .tx(tx_a), .tx_busy(tx_busy_a), .tx_done(tx_done_a)
  );

  uart_tx_buf #(.DEPTH(4), .PARITY_EN(1)) dut_b (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .bus(bus_b.slave),
    .tx(tx_b), .tx_busy(tx_busy_b), .tx_done(tx_done_b)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Count busy clocks and done pulses as seen just before each rising edge.
  always @(posedge clk) begin
    if (tx_busy_a) busy_clks_a <= busy_clks_a + 1;
    if (tx_done_a) done_cnt_a  <= done_cnt_a + 1;
    if (tx_busy_b) busy_clks_b <= busy_clks_b + 1;
    if (tx_done_b) done_cnt_b  <= done_cnt_b + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One-cycle write into instance A (sel=0) or B (sel=1).
  task automatic applyStimulus(input logic [7:0] d, input bit sel);
    if (sel) begin bus_b.tx_wr = 1'b1; bus_b.tx_wdata = d; end
    else     begin bus_a.tx_wr = 1'b1; bus_a.tx_wdata = d; end
    @(posedge clk); #1;
    bus_a.tx_wr = 1'b0;
    bus_b.tx_wr = 1'b0;
  endtask

  // One baud tick (optionally with a simultaneous write to A), then 3 quiet clocks.
  task automatic tick(input bit wr, input logic [7:0] d);
    baud_tick = 1'b1;
    if (wr) begin bus_a.tx_wr = 1'b1; bus_a.tx_wdata = d; end
    @(posedge clk); #1;
    baud_tick   = 1'b0;
    bus_a.tx_wr = 1'b0;
    rec_a[tick_idx] = tx_a;
    rec_b[tick_idx] = tx_b;
    busy_all = busy_all & tx_busy_a;
    tick_idx++;
    repeat (3) begin @(posedge clk); #1; end
  endtask

  function automatic logic [7:0] byte_a(input int base);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = rec_a[base + 1 + i];
    return b;
  endfunction

  function automatic logic [7:0] byte_b(input int base);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = rec_b[base + 1 + i];
    return b;
  endfunction

  // Directed test sequence.
  initial begin
    logic [9:0]  v10;
    logic [19:0] v20;
    int b0, d0, db0;
    int next_w;

    reset = 1'b1;
    baud_tick = 1'b0;
    bus_a.tx_wr = 1'b0; bus_a.tx_wdata = '0;
    bus_b.tx_wr = 1'b0; bus_b.tx_wdata = '0;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] reset state");
    checkOutput("rst_tx",    32'(tx_a), 32'd1);
    checkOutput("rst_busy",  32'(tx_busy_a), 32'd0);
    checkOutput("rst_done",  32'(tx_done_a), 32'd0);
    checkOutput("rst_ovf",   32'(bus_a.tx_ovf), 32'd0);
    checkOutput("rst_count", 32'(bus_a.tx_count), 32'd0);
    checkOutput("rst_empty", 32'(bus_a.tx_empty), 32'd1);
    checkOutput("rst_full",  32'(bus_a.tx_full), 32'd0);
    reset = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    $display("[TB] single byte 0xA5");
    applyStimulus(8'hA5, 1'b0);
    checkOutput("single_count", 32'(bus_a.tx_count), 32'd1);
    checkOutput("single_empty", 32'(bus_a.tx_empty), 32'd0);
    b0 = busy_clks_a; d0 = done_cnt_a; tick_idx = 0;
    tick(1'b0, 8'h00);
    checkOutput("single_start_busy", 32'(tx_busy_a), 32'd1);
    checkOutput("single_start_tx",   32'(tx_a), 32'd0);
    checkOutput("single_popped_empty", 32'(bus_a.tx_empty), 32'd1);
    for (int i = 1; i < 11; i++) tick(1'b0, 8'h00);
    for (int i = 0; i < 10; i++) v10[i] = rec_a[i];
    checkOutput("single_bits", 32'(v10), 32'(10'b1101001010));
    checkOutput("single_busy_clks", 32'(busy_clks_a - b0), 32'd40);
    checkOutput("single_done", 32'(done_cnt_a - d0), 32'd1);
    checkOutput("single_idle_busy", 32'(tx_busy_a), 32'd0);
    checkOutput("single_idle_tx", 32'(tx_a), 32'd1);

    $display("[TB] back-to-back 0x00, 0xFF");
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'hFF, 1'b0);
    checkOutput("b2b_count", 32'(bus_a.tx_count), 32'd2);
    b0 = busy_clks_a; d0 = done_cnt_a; tick_idx = 0; busy_all = 1'b1;
    for (int i = 0; i < 20; i++) tick(1'b0, 8'h00);
    for (int i = 0; i < 20; i++) v20[i] = rec_a[i];
    checkOutput("b2b_bits", 32'(v20), 32'(20'b1111111110_1000000000));
    checkOutput("b2b_busy_held", 32'(busy_all), 32'd1);
    tick(1'b0, 8'h00);
    checkOutput("b2b_done", 32'(done_cnt_a - d0), 32'd2);
    checkOutput("b2b_busy_clks", 32'(busy_clks_a - b0), 32'd80);
    checkOutput("b2b_end_busy", 32'(tx_busy_a), 32'd0);

    $display("[TB] overflow");
    for (int i = 1; i <= 5; i++) applyStimulus(8'(i), 1'b0);
    checkOutput("ovf_count", 32'(bus_a.tx_count), 32'd4);
    checkOutput("ovf_full",  32'(bus_a.tx_full), 32'd1);
    checkOutput("ovf_flag",  32'(bus_a.tx_ovf), 32'd1);
    tick_idx = 0;
    for (int i = 0; i < 41; i++) tick(1'b0, 8'h00);
    checkOutput("ovf_frame0", 32'(byte_a(0)),  32'h01);
    checkOutput("ovf_frame1", 32'(byte_a(10)), 32'h02);
    checkOutput("ovf_frame2", 32'(byte_a(20)), 32'h03);
    checkOutput("ovf_frame3", 32'(byte_a(30)), 32'h04);
    checkOutput("ovf_drained_busy", 32'(tx_busy_a), 32'd0);
    checkOutput("ovf_drained_empty", 32'(bus_a.tx_empty), 32'd1);
    checkOutput("ovf_sticky", 32'(bus_a.tx_ovf), 32'd1);

    $display("[TB] parity 0x07, 0x03");
    applyStimulus(8'h07, 1'b1);
    applyStimulus(8'h03, 1'b1);
    b0 = busy_clks_b; db0 = done_cnt_b; tick_idx = 0;
    for (int i = 0; i < 23; i++) tick(1'b0, 8'h00);
    checkOutput("par_byte0", 32'(byte_b(0)), 32'h07);
    checkOutput("par_bit0",  32'(rec_b[9]), 32'd1);
    checkOutput("par_stop0", 32'(rec_b[10]), 32'd1);
    checkOutput("par_start1", 32'(rec_b[11]), 32'd0);
    checkOutput("par_byte1", 32'(byte_b(11)), 32'h03);
    checkOutput("par_bit1",  32'(rec_b[20]), 32'd0);
    checkOutput("par_busy_clks", 32'(busy_clks_b - b0), 32'd88);
    checkOutput("par_done", 32'(done_cnt_b - db0), 32'd2);

    $display("[TB] reset mid-frame");
    applyStimulus(8'h52, 1'b0);
    applyStimulus(8'h33, 1'b0);
    tick_idx = 0;
    for (int i = 0; i < 5; i++) tick(1'b0, 8'h00);
    checkOutput("mid_bit3", 32'(rec_a[4]), 32'd0);
    checkOutput("mid_busy", 32'(tx_busy_a), 32'd1);
    checkOutput("mid_count", 32'(bus_a.tx_count), 32'd1);
    d0 = done_cnt_a;
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_tx", 32'(tx_a), 32'd1);
    checkOutput("mid_rst_busy", 32'(tx_busy_a), 32'd0);
    checkOutput("mid_rst_count", 32'(bus_a.tx_count), 32'd0);
    checkOutput("mid_rst_empty", 32'(bus_a.tx_empty), 32'd1);
    checkOutput("mid_rst_ovf", 32'(bus_a.tx_ovf), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    tick(1'b0, 8'h00);
    checkOutput("post_rst_idle_busy", 32'(tx_busy_a), 32'd0);
    checkOutput("post_rst_idle_tx", 32'(tx_a), 32'd1);
    tick(1'b1, 8'hC3);
    checkOutput("wr_on_tick_busy", 32'(tx_busy_a), 32'd0);
    checkOutput("wr_on_tick_count", 32'(bus_a.tx_count), 32'd1);
    tick_idx = 0;
    tick(1'b0, 8'h00);
    checkOutput("next_tick_busy", 32'(tx_busy_a), 32'd1);
    checkOutput("next_tick_tx", 32'(tx_a), 32'd0);
    for (int i = 0; i < 10; i++) tick(1'b0, 8'h00);
    checkOutput("post_rst_byte", 32'(byte_a(0)), 32'hC3);
    checkOutput("post_rst_done", 32'(done_cnt_a - d0), 32'd1);

    $display("[TB] wrap and simultaneous push/pop");
    wbytes[0] = 8'h3C; wbytes[1] = 8'hC3; wbytes[2] = 8'h81; wbytes[3] = 8'h7E;
    wbytes[4] = 8'h01; wbytes[5] = 8'h80; wbytes[6] = 8'h55; wbytes[7] = 8'hAA;
    wbytes[8] = 8'h0F; wbytes[9] = 8'hF0;
    applyStimulus(wbytes[0], 1'b0);
    applyStimulus(wbytes[1], 1'b0);
    checkOutput("wrap_pre_count", 32'(bus_a.tx_count), 32'd2);
    tick_idx = 0;
    tick(1'b1, wbytes[2]);
    checkOutput("wrap_pushpop_count", 32'(bus_a.tx_count), 32'd2);
    next_w = 3;
    for (int t = 2; t <= 101; t++) begin
      if (((t - 1) % 10 == 0) && next_w < 10) begin
        tick(1'b1, wbytes[next_w]);
        next_w++;
        if (t == 11) checkOutput("wrap_pushpop_count2", 32'(bus_a.tx_count), 32'd2);
      end else begin
        tick(1'b0, 8'h00);
      end
    end
    for (int k = 0; k < 10; k++)
      checkOutput($sformatf("wrap_order%0d", k), 32'(byte_a(k * 10)), 32'(wbytes[k]));
    checkOutput("wrap_end_busy", 32'(tx_busy_a), 32'd0);
    checkOutput("wrap_end_empty", 32'(bus_a.tx_empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
